cpu: RTL and testbench



---
 rtl/cpu.sv | 155 +++++++++++++++
 tb/tb_cpu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
`default_nettype none
// ============================================================================
// Module      : cpu
// Description : Minimal 8051-style accumulator CPU core. It fetches opcodes
//               and optional operand bytes over a read-only 8-bit program bus
//               and executes accumulator and carry instructions.
//               Optional feature macro: CPU_IMM_EN enables the two-byte
//               opcodes MOV A,#d (0x74), ADD A,#d (0x24) and SJMP rel (0x80).
// Revision    : 1.0 - initial release
// ============================================================================
module cpu (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active-low
  inout  wire  [7:0] data_bus,   // sampled only; never driven by the CPU
  output logic [7:0] addr_bus,
  output logic       read_en
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_OPND  = 2'd2,
    S_EXEC  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] acc_q, acc_d;
  logic       cy_q, cy_d;
  // Address of the most recent bus read, shown on addr_bus while idle/executing
  logic [7:0] addr_hold_q, addr_hold_d;

  // Architectural names used by hierarchical observers and by the logic below
  state_t     state;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [7:0] acc;
  logic       cy;

  assign state = state_q;
  assign pc    = pc_q;
  assign ir    = ir_q;
  assign acc   = acc_q;
  assign cy    = cy_q;

`ifdef CPU_IMM_EN
  logic [7:0] imm_q, imm_d;
  logic [7:0] imm;
  assign imm = imm_q;
`endif

  // State register and architectural registers; reset aborts any instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= 8'h00;
      ir_q        <= 8'h00;
      acc_q       <= 8'h00;
      cy_q        <= 1'b0;
      addr_hold_q <= 8'h00;
`ifdef CPU_IMM_EN
      imm_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      cy_q        <= cy_d;
      addr_hold_q <= addr_hold_d;
`ifdef CPU_IMM_EN
      imm_q       <= imm_d;
`endif
    end
  end

  // Next-state, bus outputs and instruction execution
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    ir_d        = ir;
    acc_d       = acc;
    cy_d        = cy;
    addr_hold_d = addr_hold_q;
`ifdef CPU_IMM_EN
    imm_d       = imm;
`endif
    read_en     = 1'b0;
    addr_bus    = addr_hold_q;

    case (state)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        read_en     = 1'b1;
        addr_bus    = pc;
        addr_hold_d = pc;
        ir_d        = data_bus;
        pc_d        = pc + 8'd1;
`ifdef CPU_IMM_EN
        // Operand-bearing opcodes are recognised straight off the bus
        if (data_bus == 8'h74 || data_bus == 8'h24 || data_bus == 8'h80)
          state_d = S_OPND;
        else
          state_d = S_EXEC;
`else
        state_d = S_EXEC;
`endif
      end

`ifdef CPU_IMM_EN
      S_OPND: begin
        read_en     = 1'b1;
        addr_bus    = pc;
        addr_hold_d = pc;
        imm_d       = data_bus;
        pc_d        = pc + 8'd1;
        state_d     = S_EXEC;
      end
`endif

      S_EXEC: begin
        state_d = S_FETCH;
        case (ir)
          8'h04: acc_d = acc + 8'd1;
          8'h14: acc_d = acc - 8'd1;
          8'hE4: acc_d = 8'h00;
          8'hF4: acc_d = ~acc;
          8'h23: acc_d = {acc[6:0], acc[7]};
          8'h03: acc_d = {acc[0], acc[7:1]};
          8'h33: {cy_d, acc_d} = {acc, cy};
          8'h13: {acc_d, cy_d} = {cy, acc};
          8'hC3: cy_d = 1'b0;
          8'hD3: cy_d = 1'b1;
`ifdef CPU_IMM_EN
          8'h74: acc_d = imm;
          8'h24: {cy_d, acc_d} = {1'b0, acc} + {1'b0, imm};
          // pc already points past the operand; 8-bit add equals sign-extended offset
          8'h80: pc_d = pc + imm;
`endif
          default: ; // NOP and all undefined opcodes
        endcase
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu
// Description : Scoreboard bench for cpu. An instruction-level model of the
//               program in memory produces the expected per-cycle bus
//               activity and register values; a monitor compares each cycle.
//               Works with or without CPU_IMM_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  wire  [7:0] data_bus;
  logic [7:0] addr_bus;
  logic       read_en;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       ren;
    logic [7:0] addr;
    logic       chk;
    logic [7:0] acc;
    logic       cy;
  } cyc_t;

  cyc_t       expq[$];
  logic       mon_en = 1'b0;
  logic [7:0] fin_acc;
  logic       fin_cy;

  cpu dut (
    .clk      (clk),
    .reset    (reset),
    .data_bus (data_bus),
    .addr_bus (addr_bus),
    .read_en  (read_en)
  );

  // Program memory answers combinationally within the cycle
  assign data_bus = mem[addr_bus];

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic ren, input logic [7:0] addr, input logic chk,
                      input logic [7:0] a, input logic c);
    cyc_t e;
    e.ren = ren; e.addr = addr; e.chk = chk; e.acc = a; e.cy = c;
    expq.push_back(e);
  endtask

  // Instruction-level interpreter: one idle cycle, then per instruction a
  // fetch cycle, an optional operand cycle and an execute cycle.
  task automatic model_run(input int n);
    logic [7:0] pc   = 8'h00;
    logic [7:0] a    = 8'h00;
    logic       c    = 1'b0;
    logic [7:0] last = 8'h00;
    logic [7:0] op;
    logic [7:0] d;
    logic       two;
    logic [8:0] t;
    push(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (n) begin
      op = mem[pc];
      push(1'b1, pc, 1'b1, a, c);
      last = pc;
      pc   = pc + 8'd1;
      d    = 8'h00;
      two  = 1'b0;
`ifdef CPU_IMM_EN
      two = (op == 8'h74) || (op == 8'h24) || (op == 8'h80);
`endif
      if (two) begin
        d = mem[pc];
        push(1'b1, pc, 1'b0, 8'h00, 1'b0);
        last = pc;
        pc   = pc + 8'd1;
      end
      push(1'b0, last, 1'b0, 8'h00, 1'b0);
      case (op)
        8'h04: a = a + 8'd1;
        8'h14: a = a - 8'd1;
        8'hE4: a = 8'h00;
        8'hF4: a = 8'hFF - a;
        8'h23: a = (a << 1) | (a >> 7);
        8'h03: a = (a >> 1) | (a << 7);
        8'h33: begin t = a * 2 + c; c = t[8]; a = t[7:0]; end
        8'h13: begin t = c * 256 + a; c = t[0]; a = t[8:1]; end
        8'hC3: c = 1'b0;
        8'hD3: c = 1'b1;
`ifdef CPU_IMM_EN
        8'h74: a = d;
        8'h24: begin t = a + d; a = t[7:0]; c = t[8]; end
        8'h80: pc = pc + d;
`endif
        default: ;
      endcase
    end
    fin_acc = a;
    fin_cy  = c;
  endtask

  // Monitor: one expected entry per clock once the CPU leaves reset
  always @(negedge clk) begin
    if (mon_en && expq.size() > 0) begin
      cyc_t e;
      e = expq.pop_front();
      check8("read_en", {7'd0, read_en}, {7'd0, e.ren});
      check8("addr_bus", addr_bus, e.addr);
      if (e.chk) begin
        check8("acc_at_fetch", dut.acc, e.acc);
        check8("cy_at_fetch", {7'd0, dut.cy}, {7'd0, e.cy});
      end
    end
  end

  // Asynchronous reset asserted mid-cycle, held for the given clock count
  task automatic do_reset(input int cycles);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check8("rst_read_en", {7'd0, read_en}, 8'h00);
    check8("rst_addr", addr_bus, 8'h00);
    check8("rst_acc", dut.acc, 8'h00);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check8("rst_hold_read_en", {7'd0, read_en}, 8'h00);
    check8("rst_hold_addr", addr_bus, 8'h00);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Reset, run n instructions against the model, then check final registers
  task automatic run_prog(input int n);
    int budget;
    expq.delete();
    model_run(n);
    budget = expq.size() + 20;
    do_reset(15);
    mon_en = 1'b1;
    while (expq.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    mon_en = 1'b0;
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got %0d pending entries expected 0", expq.size());
    end
    @(negedge clk);
    check8("final_acc", dut.acc, fin_acc);
    check8("final_cy", {7'd0, dut.cy}, {7'd0, fin_cy});
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3; mem[4] = b4; mem[5] = b5;
  endtask

  logic [7:0] ops [14] = '{8'h00, 8'h04, 8'h14, 8'hE4, 8'hF4, 8'h23, 8'h03,
                           8'h33, 8'h13, 8'hC3, 8'hD3, 8'h74, 8'h24, 8'h80};

  initial begin
    // Stream INC, NOP, DEC repeating
    for (int i = 0; i < 256; i++) mem[i] = (i % 3 == 0) ? 8'h04 : ((i % 3 == 1) ? 8'h00 : 8'h14);
    run_prog(30);
    check8("stream_acc", dut.acc, 8'h00);

    // DEC from zero then INC, carry preserved
    load(8'hD3, 8'h14, 8'h04, 8'h00, 8'h00, 8'h00);
    run_prog(2);
    check8("dec_wrap_acc", dut.acc, 8'hFF);
    check8("dec_wrap_cy", {7'd0, dut.cy}, 8'h01);
    run_prog(3);
    check8("inc_wrap_acc", dut.acc, 8'h00);

    // Carry and rotate through carry
    load(8'hD3, 8'hE4, 8'h13, 8'h33, 8'h00, 8'h00);
    run_prog(3);
    check8("rrc_acc", dut.acc, 8'h80);
    check8("rrc_cy", {7'd0, dut.cy}, 8'h00);
    run_prog(4);
    check8("rlc_acc", dut.acc, 8'h00);
    check8("rlc_cy", {7'd0, dut.cy}, 8'h01);

    // PC wrap over all-NOP memory
    load(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_prog(260);
    check8("wrap_addr_hold", addr_bus, 8'h04);

    // Immediate program; a set of NOP-equivalents when the feature is off
    load(8'h74, 8'hF0, 8'h24, 8'h20, 8'h80, 8'hFE);
    run_prog(10);
`ifdef CPU_IMM_EN
    check8("imm_acc", dut.acc, 8'h10);
    check8("imm_cy", {7'd0, dut.cy}, 8'h01);
`else
    check8("noimm_acc", dut.acc, 8'h00);
`endif

    // Randomized programs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++)
        mem[i] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ops[$urandom_range(0, 13)];
      run_prog(120);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
